// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared pipeline control types and constants
package pipeline_ctrl_pkg;
  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} ctrl_state_e;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs, data-memory handshake and stage control outputs
interface pipeline_ctrl_if;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used, ex_is_load, ex_redirect;
  logic       mem_req, mem_ack;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  modport master (
    output id_rs1_addr, id_rs2_addr, ex_rd_addr, id_rs1_used, id_rs2_used,
           ex_is_load, ex_redirect, mem_req, mem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_err
  );
  modport slave (
    input  id_rs1_addr, id_rs2_addr, ex_rd_addr, id_rs1_used, id_rs2_used,
           ex_is_load, ex_redirect, mem_req, mem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_err
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the ID sources and the EX load destination
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd_addr,
  input  logic       is_load,
  output logic       load_use
);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  always_comb begin
    load_use = is_load && rd_addr != REG_X0 &&
               ((rs1_used && rs1_addr == rd_addr) || (rs2_used && rs2_addr == rd_addr));
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage pipeline; PIPE_CTRL_PERF_EN adds stall_cnt/flush_cnt
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave p
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]    stall_cnt,
  output logic [31:0]    flush_cnt
`endif
);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  ctrl_state_e state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        load_use, timed_out, mem_stall, redirect, lu_stall;

  hazard_detect u_hazard (
    .rs1_addr (p.id_rs1_addr),
    .rs2_addr (p.id_rs2_addr),
    .rs1_used (p.id_rs1_used),
    .rs2_used (p.id_rs2_used),
    .rd_addr  (p.ex_rd_addr),
    .is_load  (p.ex_is_load),
    .load_use (load_use)
  );

  // state and wait counter update on the falling edge, alongside the pipeline registers
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // enter MEM_WAIT on an unacknowledged request; leave on ack or when the wait budget runs out
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (state_q == RUN) begin
      if (p.mem_req && !p.mem_ack) begin
        state_d = MEM_WAIT;
        wcnt_d  = 8'd1;
      end
    end else if (p.mem_ack || timed_out) begin
      state_d = RUN;
      wcnt_d  = '0;
    end else begin
      wcnt_d = wcnt_q + 8'd1;
    end
  end

  // priority: memory stall > redirect > load-use > normal flow; reset freezes and bubbles every stage
  always_comb begin
    timed_out      = state_q == MEM_WAIT && !p.mem_ack && wcnt_q == TIMEOUT;
    mem_stall      = state_q == RUN ? p.mem_req && !p.mem_ack : !p.mem_ack && !timed_out;
    redirect       = !mem_stall && p.ex_redirect;
    lu_stall       = !mem_stall && !p.ex_redirect && load_use;
    p.pc_en        = rst_n && !mem_stall && !lu_stall;
    p.if_id_en     = rst_n && !mem_stall && !lu_stall;
    p.id_ex_en     = rst_n && !mem_stall;
    p.ex_mem_en    = rst_n && !mem_stall;
    p.mem_wb_en    = rst_n;
    p.if_id_flush  = !rst_n || redirect;
    p.id_ex_flush  = !rst_n || redirect || lu_stall;
    p.mem_wb_flush = !rst_n || mem_stall;
    p.mem_err      = rst_n && timed_out;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // count frozen-PC cycles and redirect-driven ID/EX bubbles; both wrap naturally
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(!p.pc_en);
    flush_cnt_d = flush_cnt_q + 32'(redirect);
  end

  // performance counters sample on the same edge as the pipeline
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and randomized checks of pipeline_ctrl against a cycle-level behavioural model
module tb_pipeline_ctrl;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int pending = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  pipeline_ctrl_if pif ();
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p     (pif)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // one pipeline cycle: drive inputs after the rising edge, check outputs, then advance the model at the falling edge
  task automatic step(input string tag, input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                      input logic redir, input logic req, input logic ack);
    logic active, err, ms, rdr, lu;
    logic [8:0] exp, got;
    @(posedge clk);
    rst_n = rst;
    pif.id_rs1_addr = rs1; pif.id_rs2_addr = rs2; pif.id_rs1_used = u1; pif.id_rs2_used = u2;
    pif.ex_rd_addr = rd; pif.ex_is_load = ld; pif.ex_redirect = redir;
    pif.mem_req = req; pif.mem_ack = ack;
    #1;
    active = pending > 0 || req;
    err = rst && active && !ack && pending == T;
    ms  = rst && active && !ack && !err;
    rdr = rst && !ms && redir;
    lu  = rst && !ms && !redir && ld && rd != 5'd0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!rst) exp = 9'b00000_111_0;
    else exp = {!(ms || lu), !(ms || lu), !ms, !ms, 1'b1, rdr, rdr || lu, ms, err};
    got = {pif.pc_en, pif.if_id_en, pif.id_ex_en, pif.ex_mem_en, pif.mem_wb_en,
           pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_flush, pif.mem_err};
    check(tag, 32'(got), 32'(exp));
    @(negedge clk);
    if (!rst) begin
      pending = 0; m_stall = 0; m_flush = 0;
    end else begin
      pending = ms ? pending + 1 : 0;
      m_stall += 32'(ms || lu);
      m_flush += 32'(rdr);
    end
`ifdef PIPE_CTRL_PERF_EN
    #1;
    check({tag, "_stall_cnt"}, stall_cnt, m_stall);
    check({tag, "_flush_cnt"}, flush_cnt, m_flush);
`endif
  endtask

  initial begin
    step("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("load_use", 1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
    step("after_lu", 1, 5, 0, 1, 0, 7, 0, 0, 0, 0);
    step("lu_rs2", 1, 1, 9, 0, 1, 9, 1, 0, 0, 0);
    step("lu_unused", 1, 9, 9, 0, 0, 9, 1, 0, 0, 0);
    step("x0", 1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("lu_redir", 1, 5, 0, 1, 0, 5, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("mwait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("mwait_ack", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("mwait_done", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < T + 1; i++) step("tmo", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("tmo_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("redir_stall", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("redir_ack", 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    step("redir_done", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("rst_wait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rst_out", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step("rand", $urandom_range(99) != 0,
           5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom), 1'($urandom),
           5'($urandom_range(3)), 1'($urandom), $urandom_range(4) == 0,
           $urandom_range(3) == 0, $urandom_range(9) < 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
